// File: rtl/add_pipe.sv
// add_pipe: chunked, elastic, pipelined adder/subtractor/comparator.
//
// The WIDTH+1 bit sum A + B' + cin is computed WIDTH/STAGES bits at a time.
// Stage k adds chunk k using the carry registered by stage k-1, so no clock
// period contains a full-width carry chain. Operands, completed result chunks,
// op and (optionally) a running zero flag travel with each operation.
//
// Parameters
//   WIDTH   operand/result width (default 32)
//   STAGES  pipeline depth, 1..4, WIDTH must be a multiple of STAGES
//
// Ports
//   clk_i        sole clock, rising edge
//   rst_i        asynchronous active-high reset, empties the pipeline
//   in_valid_i   operation presented
//   in_ready_o   operation accepted when high with in_valid_i
//   op_i         00 ADD, 01 SUB, 10 SLT, 11 SLTU
//   opa_i/opb_i  operands A and B
//   flush_i      discard every in-flight operation (and the one offered now)
//   out_valid_o  result available
//   out_ready_i  consumer takes the result when high with out_valid_o
//   result_o     sum, or the SLT/SLTU 0/1 result
//   flags_o      {c, n, v, z} of the raw sum
//
// Build option
//   ADD_PIPE_FLAGS_EN  defined: flags_o carries {c,n,v,z}, including a
//                      pipelined running zero flag.
//                      undefined: flags_o is 0 and no zero registers exist.
module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SLT  = 2'b10;
    localparam logic [1:0] OP_SLTU = 2'b11;

    // Per-stage state
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [1:0]        op_q  [STAGES];
    logic [1:0]        op_d  [STAGES];
`ifdef ADD_PIPE_FLAGS_EN
    logic [STAGES-1:0] z_q, z_d;
    logic [STAGES-1:0] src_z;
`endif

    // What each stage sees as its input: stage 0 the ports, others the
    // previous stage's registers.
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_r   [STAGES];
    logic [1:0]        src_op  [STAGES];
    logic [STAGES-1:0] src_c;

    logic [STAGES-1:0] adv;    // stage hands its content onward this cycle
    logic [STAGES-1:0] load;   // stage captures new content this cycle
    logic              in_ready;

    // ------------------------------------------------------------------
    // Handshake: walk from the output back to the input. A stage may move
    // on when the slot after it is free, i.e. empty or itself moving on.
    // ------------------------------------------------------------------
    always_comb begin
        logic free;
        adv  = '0;
        load = '0;
        free = out_ready_i;
        for (int k = LAST; k >= 0; k--) begin
            adv[k] = valid_q[k] && free;
            free   = !valid_q[k] || adv[k];
        end
        in_ready = free;

        // An input offered together with flush is dropped.
        load[0] = in_valid_i && in_ready && !flush_i;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            if (flush_i) begin
                valid_d[k] = 1'b0;
            end else if (load[k]) begin
                valid_d[k] = 1'b1;
            end else if (adv[k]) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath: stage k adds chunk k of the operands.
    // ------------------------------------------------------------------
    always_comb begin
        logic [CW:0] chunk;

        // B is inverted and cin forced to 1 for every subtract-style op.
        src_a[0]  = opa_i;
        src_b[0]  = (op_i == OP_ADD) ? opb_i : ~opb_i;
        src_r[0]  = '0;
        src_c[0]  = (op_i != OP_ADD);
        src_op[0] = op_i;
`ifdef ADD_PIPE_FLAGS_EN
        src_z[0]  = 1'b1;
`endif
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]  = a_q[k-1];
            src_b[k]  = b_q[k-1];
            src_r[k]  = res_q[k-1];
            src_c[k]  = c_q[k-1];
            src_op[k] = op_q[k-1];
`ifdef ADD_PIPE_FLAGS_EN
            src_z[k]  = z_q[k-1];
`endif
        end

        chunk = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, src_a[k][k*CW +: CW]}
                  + {1'b0, src_b[k][k*CW +: CW]}
                  + {{CW{1'b0}}, src_c[k]};
            a_d[k]   = src_a[k];
            b_d[k]   = src_b[k];
            op_d[k]  = src_op[k];
            res_d[k] = src_r[k];
            res_d[k][k*CW +: CW] = chunk[CW-1:0];
            c_d[k]   = chunk[CW];
`ifdef ADD_PIPE_FLAGS_EN
            z_d[k]   = src_z[k] && (chunk[CW-1:0] == '0);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage registers. Data registers only move when a stage loads, which
    // keeps a stalled output stage stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            c_q     <= '0;
`ifdef ADD_PIPE_FLAGS_EN
            z_q     <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
                op_q[k]  <= OP_ADD;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    res_q[k] <= res_d[k];
                    op_q[k]  <= op_d[k];
                    c_q[k]   <= c_d[k];
`ifdef ADD_PIPE_FLAGS_EN
                    z_q[k]   <= z_d[k];
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: the operand sign bits are still in the last stage's
    // registers, so n/v/c come straight from there.
    // ------------------------------------------------------------------
    logic n_w, v_w, c_w;

    always_comb begin
        n_w = res_q[LAST][WIDTH-1];
        v_w = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
              (res_q[LAST][WIDTH-1] != b_q[LAST][WIDTH-1]);
        c_w = c_q[LAST];

        case (op_q[LAST])
            OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, n_w ^ v_w};
            OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, ~c_w};
            default: result_o = res_q[LAST];
        endcase

`ifdef ADD_PIPE_FLAGS_EN
        flags_o = {c_w, n_w, v_w, z_q[LAST]};
`else
        flags_o = 4'b0000;
`endif
    end

    assign out_valid_o = valid_q[LAST];
    assign in_ready_o  = in_ready;

endmodule

// File: tb/tb_add_pipe.sv
// Testbench for add_pipe (WIDTH=32, STAGES=2): directed literal cases plus a
// randomized run checked against an arithmetic reference model.
module tb_add_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
`ifdef ADD_PIPE_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .opa_i       (opa),
        .opb_i       (opb),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .flags_o     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    // Returns {result[31:0], flags[3:0]}.
    function automatic logic [35:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bp;
        logic [32:0] s;
        logic [31:0] r;
        logic        c, n, v, z;
        bp = (o == 2'b00) ? b : ~b;
        s  = {1'b0, a} + {1'b0, bp} + ((o == 2'b00) ? 33'd0 : 33'd1);
        c  = s[32];
        n  = s[31];
        v  = (a[31] == bp[31]) && (s[31] != bp[31]);
        z  = (s[31:0] == 32'd0);
        case (o)
            2'b10:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            2'b11:   r = (a < b) ? 32'd1 : 32'd0;
            default: r = s[31:0];
        endcase
        return {r, (FLAGS_ON ? {c, n, v, z} : 4'b0000)};
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard / compare process, samples on the falling edge.
    // ------------------------------------------------------------------
    logic [35:0] exp_q [$];
    logic [31:0] seen_q [$];
    logic        prev_stall = 1'b0;
    logic        prev_flush = 1'b0;
    logic [31:0] prev_res;
    logic [3:0]  prev_flags;

    always @(negedge clk) begin
        logic [35:0] e;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            if (prev_stall && !prev_flush) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {result, flags}, {prev_res, prev_flags});
            end
            if (exp_q.size() >= STAGES && !out_ready)
                check("full_in_ready", in_ready, 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("result", result, e[35:4]);
                    check("flags", flags, e[3:0]);
                    seen_q.push_back(result);
                    $display("[TB] out result=0x%08h flags=%04b expected=0x%08h/%04b",
                             result, flags, e[35:4], e[3:0]);
                end
            end
            if (flush)
                exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back(model(op, opa, opb));
            prev_stall = out_valid && !out_ready;
            prev_flush = flush;
            prev_res   = result;
            prev_flags = flags;
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers. All driving happens 1 time unit after posedge.
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated operation into an empty pipe: literal result/flags and latency.
    task automatic single(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_f);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op  = o;
        opa = a;
        opb = b;
        @(negedge clk);
        check({nm, "_accept"}, in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            next_cycle();
            lat++;
        end
        check({nm, "_latency"}, lat, STAGES);
        check({nm, "_result"}, result, exp_r);
        check({nm, "_flags"}, flags, exp_f & {4{FLAGS_ON}});
        next_cycle();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'(($urandom_range(0, 15)));
            5:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int i;
        int acc;
        int guard;
        int quiet;

        rst = 1'b1; in_valid = 1'b0; op = 2'b00; opa = '0; opb = '0;
        flush = 1'b0; out_ready = 1'b0;
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        next_cycle();

        // Literal corner cases
        single("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001);
        single("sub_ovf",  2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1010);
        single("slt",      2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b1100);
        single("sltu",     2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100);

        // Back-to-back ADDs against a stalled consumer
        seen_q.delete();
        out_ready = 1'b0;
        i = 0;
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (i < 4);
            op  = 2'b00;
            opa = 32'(i);
            opb = 32'h10;
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc++;
                i++;
            end
            if (cyc == 4) check("stall_in_ready_low", in_ready, 0);
            next_cycle();
        end
        check("stall_accepted", acc, 2);
        out_ready = 1'b1;
        guard = 0;
        while (i < 4 && guard < 20) begin
            in_valid = 1'b1;
            opa = 32'(i);
            @(negedge clk);
            if (in_ready) i++;
            guard++;
            next_cycle();
        end
        in_valid = 1'b0;
        repeat (6) next_cycle();
        check("stall_count", seen_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < seen_q.size()) check("stall_order", seen_q[k], 32'h10 + 32'(k));
        end

        // Flush with two operations in flight
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            op  = 2'b00;
            opa = 32'(k + 1);
            opb = 32'h2;
            @(negedge clk);
            check("flush_pre_accept", in_ready, 1);
            next_cycle();
        end
        seen_q.delete();
        flush = 1'b1;
        opa = 32'h55;
        next_cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!out_valid) quiet++;
            next_cycle();
        end
        check("flush_quiet_cycles", quiet, 4);
        check("flush_nothing_seen", seen_q.size(), 0);
        single("post_flush_add", 2'b00, 32'd3, 32'd4, 32'd7, 4'b0000);

        // Asynchronous reset with two operations in flight
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            op  = 2'b01;
            opa = 32'h100;
            opb = 32'(k);
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_out_valid", out_valid, 0);
        seen_q.delete();
        next_cycle();
        rst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (!out_valid) quiet++;
            next_cycle();
        end
        check("reset_quiet_cycles", quiet, 5);
        check("reset_nothing_seen", seen_q.size(), 0);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            op        = 2'($urandom_range(0, 3));
            opa       = rand_operand();
            opb       = rand_operand();
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 99) < 3);
            next_cycle();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (10) next_cycle();
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add_pipe.md
ADD_PIPE -- requirements
Module: add_pipe

Interface
- REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
- REQ-002 SHALL have parameter STAGES, default 2: pipeline depth; legal 1..4; WIDTH % STAGES == 0.
- REQ-003 SHALL have port clk_i  input  1  sole clock; all state on its rising edge.
- REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
- REQ-005 SHALL have port in_valid_i  input  1  operation presented.
- REQ-006 SHALL have port in_ready_o  output  1  operation accepted when high with in_valid_i.
- REQ-007 SHALL have port op_i  input  2  00 ADD, 01 SUB, 10 SLT, 11 SLTU.
- REQ-008 SHALL have port opa_i  input  WIDTH  operand A.
- REQ-009 SHALL have port opb_i  input  WIDTH  operand B.
- REQ-010 SHALL have port flush_i  input  1  discard all in-flight operations.
- REQ-011 SHALL have port out_valid_o  output  1  result available.
- REQ-012 SHALL have port out_ready_i  input  1  consumer takes result when high with out_valid_o.
- REQ-013 SHALL have port result_o  output  WIDTH  result.
- REQ-014 SHALL have port flags_o  output  4  {c, n, v, z} for the result.

Function
- REQ-015 SHALL form B' = ~opb_i with carry-in 1 for SUB/SLT/SLTU; otherwise B' = opb_i with carry-in 0.
- REQ-016 SHALL form sum = A + B' + cin, WIDTH+1 bits; c = bit WIDTH.
- REQ-017 SHALL split the sum into STAGES chunks of WIDTH/STAGES bits; stage k adds chunk k using the carry registered by stage k-1; no full-width carry chain in one cycle.
- REQ-018 SHALL carry unprocessed operand chunks, completed result chunks, op and a running zero flag forward through stage registers.
- REQ-019 SHALL define n = sum[WIDTH-1], v = (A[W-1] == B'[W-1]) && (sum[W-1] != B'[W-1]), z = (sum[W-1:0] == 0).
- REQ-020 SHALL drive result_o = sum for ADD/SUB; for SLT result_o = {0.., n^v}; for SLTU result_o = {0.., ~c}; flags always reflect the raw sum.
- REQ-021 SHALL give latency exactly STAGES cycles from accept to out_valid_o when never stalled.
- REQ-022 SHALL sustain one accepted operation per cycle when out_ready_i stays high.
- REQ-023 SHALL advance a stage only when its successor is empty or advancing in the same cycle; in_ready_o = !valid[0] || stage 0 advancing.
- REQ-024 SHALL hold result_o/flags_o/out_valid_o stable while out_valid_o && !out_ready_i.
- REQ-025 SHALL buffer at most STAGES operations; under full stall in_ready_o SHALL be low; no operation lost, duplicated or reordered.
- REQ-026 SHALL, on flush_i, clear all stage valids at the next edge; an input offered in the flush cycle SHALL be dropped; in_ready_o SHALL be high in the cycle after flush.
- REQ-027 SHALL, when STAGES == 1, behave as a single registered stage with identical results.

Reset
- REQ-028 SHALL, on rst_i high, immediately clear all valids: out_valid_o = 0, result_o = 0, flags_o = 0, in_ready_o = 1 after release.
- REQ-029 SHALL discard in-flight operations when reset asserts mid-operation; nothing is emitted after release until new input.

Configuration
- REQ-030 SHALL honour macro ADD_PIPE_FLAGS_EN: defined -> flags computed and pipelined per REQ-019; undefined -> flags_o tied to 4'b0, no flag/zero-accumulate registers, result_o unaffected (SLT/SLTU still use internal n/v/c of final stage).

Verification (WIDTH=32, STAGES=2, flags enabled)
- REQ-031 SHALL cover ADD 0xFFFFFFFF + 0x00000001 -> result 0x00000000, flags c=1 n=0 v=0 z=1, out_valid_o exactly 2 cycles after accept.
- REQ-032 SHALL cover SUB 0x80000000 - 0x00000001 -> 0x7FFFFFFF, c=1 n=0 v=1 z=0.
- REQ-033 SHALL cover SLT 0xFFFFFFFF vs 0x00000001 -> 0x00000001; SLTU same operands -> 0x00000000.
- REQ-034 SHALL cover 4 back-to-back ADDs (i + 0x10, i=0..3) with out_ready_i low for 5 cycles -> in_ready_o low after 2 held, then results 0x10,0x11,0x12,0x13 in order, each once.
- REQ-035 SHALL cover flush_i in the cycle after accepting 2 ops -> no out_valid_o for either; a following ADD 3+4 -> 7 after 2 cycles.
- REQ-036 SHALL cover rst_i asserted asynchronously with 2 ops in flight -> out_valid_o 0 immediately, no output after release.
